// File: rtl/stage5ro_pipe.sv
// stage5ro_pipe: register-operation stage between operand fetch and write-back.
// One-entry skid buffer keeps in_ready registered and decoupled from out_ready.
module stage5ro_pipe #(
    parameter int PC_W   = 12,
    parameter int DATA_W = 24,
    parameter int REG_AW = 4,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [3:0]        op_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [DATA_W-1:0] result_out,
    output logic              wb_en_out,
    output logic              zero_out,
    output logic              carry_out,
    output logic              illegal_out
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] res;
        logic              wb_en;
        logic              carry;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t out_q, skid_q, new_e;
    logic   load_new, load_skid, move_skid;
    logic   in_fire, out_fire;

    logic [SH_W-1:0] sh;
    logic [31:0]     sh32;
    logic [DATA_W:0] wide;

    assign sh   = b_in[SH_W-1:0];
    assign sh32 = 32'(sh);

    // Decode and execute the incoming instruction.
    always_comb begin
        new_e         = '0;
        wide          = '0;
        new_e.pc      = pc_in;
        new_e.rd      = rd_in;
        new_e.wb_en   = 1'b1;
        unique case (op_in)
            4'd0: new_e.wb_en = 1'b0;
            4'd1: new_e.res = b_in;
            4'd2: begin
                wide        = {1'b0, a_in} + {1'b0, b_in};
                new_e.res   = wide[DATA_W-1:0];
                new_e.carry = wide[DATA_W];
            end
            4'd3: begin
                wide        = {1'b0, a_in} - {1'b0, b_in};
                new_e.res   = wide[DATA_W-1:0];
                new_e.carry = wide[DATA_W];
            end
            4'd4: new_e.res = a_in & b_in;
            4'd5: new_e.res = a_in | b_in;
            4'd6: new_e.res = a_in ^ b_in;
            4'd7: begin
                if (sh32 == 32'd0) begin
                    new_e.res = a_in;
                end else if (sh32 < 32'(DATA_W)) begin
                    wide        = {1'b0, a_in} << sh;
                    new_e.res   = wide[DATA_W-1:0];
                    new_e.carry = wide[DATA_W];
                end
            end
            4'd8: begin
                if (sh32 == 32'd0) begin
                    new_e.res = a_in;
                end else if (sh32 < 32'(DATA_W)) begin
                    wide        = {a_in, 1'b0} >> sh;
                    new_e.res   = wide[DATA_W:1];
                    new_e.carry = wide[0];
                end
            end
            default: begin
                new_e.wb_en   = 1'b0;
                new_e.illegal = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next state and entry-load controls; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        load_new  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_new = 1'b1;
                        state_d  = FULL;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        load_new = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = SKID;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        move_skid = 1'b1;
                        state_d   = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    // Output and skid entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_new)  out_q  <= new_e;
            if (move_skid) out_q  <= skid_q;
            if (load_skid) skid_q <= new_e;
        end
    end

    assign pc_out      = out_q.pc;
    assign rd_out      = out_q.rd;
    assign result_out  = out_q.res;
    assign wb_en_out   = out_q.wb_en;
    assign carry_out   = out_q.carry;
    assign illegal_out = out_q.illegal;
    assign zero_out    = out_valid & (out_q.res == '0);

endmodule
